// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared FSM encoding, owner IDs and default sizing for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int DEF_DEPTH       = 128;
    localparam int DEF_MEM_LATENCY = 1;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-memory arbiter (req/gnt/rvalid handshake)
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker; on a tie the requester that did not win last time wins
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner,
    output logic       any
);
    assign any    = |req;
    assign winner = (&req) ? ~last_owner : req[OWN_DMA];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU and a DMA/loader port, one access at a time
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY,
    parameter int ADDR_W      = 32
) (
    input  logic              clock_in,
    input  logic              reset_n,
    dmem_arbiter_if.slave     cpu,
    dmem_arbiter_if.slave     dma,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [31:0]       mem_read_data
);
    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [3:0]        count_q, count_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [31:0]       mem_write_data_q, mem_write_data_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic              winner, any, idle, resp;
    logic              sel_we, sel_oor;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              cpu_rvalid, dma_rvalid;

    rr_arb2 u_rr (
        .req        ({dma.req, cpu.req}),
        .last_owner (last_owner_q),
        .winner     (winner),
        .any        (any)
    );

    assign sel_we    = winner ? dma.we : cpu.we;
    assign sel_addr  = winner ? dma.addr : cpu.addr;
    assign sel_wdata = winner ? dma.wdata : cpu.wdata;
    assign sel_oor   = sel_addr >= ADDR_W'(DEPTH);

    assign idle = state_q == IDLE;
    assign resp = state_q == RESPOND;

    assign cpu.gnt    = idle && any && winner == OWN_CPU;
    assign dma.gnt    = idle && any && winner == OWN_DMA;
    assign cpu_rvalid = resp && owner_q == OWN_CPU;
    assign dma_rvalid = resp && owner_q == OWN_DMA;
    assign cpu.rvalid = cpu_rvalid;
    assign dma.rvalid = dma_rvalid;
    assign cpu.rdata  = cpu_rvalid ? rdata_q : '0;
    assign dma.rdata  = dma_rvalid ? rdata_q : '0;
    assign cpu.err    = cpu_rvalid && err_q;
    assign dma.err    = dma_rvalid && err_q;

    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_write      = mem_write_q;
    assign mem_read       = mem_read_q;

    // Next-state: grant in IDLE, hold memory strobes for the latency count, then present one response
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_owner_d     = last_owner_q;
        we_d             = we_q;
        err_d            = err_q;
        count_d          = count_q;
        rdata_d          = rdata_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        mem_write_d      = mem_write_q;
        mem_read_d       = mem_read_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    owner_d      = winner;
                    last_owner_d = winner;
                    we_d         = sel_we;
                    if (sel_oor) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESPOND;
                    end else begin
                        count_d          = 4'(MEM_LATENCY - 1);
                        mem_address_d    = sel_addr;
                        mem_write_data_d = sel_wdata;
                        mem_write_d      = sel_we;
                        mem_read_d       = !sel_we;
                        state_d          = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (count_q == 4'd0) begin
                    rdata_d     = we_q ? '0 : mem_read_data;
                    err_d       = 1'b0;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b0;
                    state_d     = RESPOND;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight access and lets the CPU win the first tie
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            owner_q          <= OWN_CPU;
            last_owner_q     <= OWN_DMA;
            we_q             <= 1'b0;
            err_q            <= 1'b0;
            count_q          <= '0;
            rdata_q          <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            mem_write_q      <= 1'b0;
            mem_read_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            last_owner_q     <= last_owner_d;
            we_q             <= we_d;
            err_q            <= err_d;
            count_q          <= count_d;
            rdata_q          <= rdata_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            mem_write_q      <= mem_write_d;
            mem_read_q       <= mem_read_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of the data-memory arbiter at memory latency 1 and 3
module tb_dmem_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32)) c1 ();
    dmem_arbiter_if #(.ADDR_W(32)) d1 ();
    dmem_arbiter_if #(.ADDR_W(32)) c3 ();
    dmem_arbiter_if #(.ADDR_W(32)) d3 ();

    logic [31:0] m1_addr, m1_wdata, m1_rdata, m3_addr, m3_wdata, m3_rdata;
    logic        m1_write, m1_read, m3_write, m3_read;
    logic [31:0] mem1 [128];
    logic [31:0] mem3 [128];

    dmem_arbiter #(.DEPTH(128), .MEM_LATENCY(1), .ADDR_W(32)) dut1 (
        .clock_in(clk), .reset_n(rst_n), .cpu(c1), .dma(d1),
        .mem_address(m1_addr), .mem_write_data(m1_wdata), .mem_write(m1_write),
        .mem_read(m1_read), .mem_read_data(m1_rdata)
    );

    dmem_arbiter #(.DEPTH(128), .MEM_LATENCY(3), .ADDR_W(32)) dut3 (
        .clock_in(clk), .reset_n(rst_n), .cpu(c3), .dma(d3),
        .mem_address(m3_addr), .mem_write_data(m3_wdata), .mem_write(m3_write),
        .mem_read(m3_read), .mem_read_data(m3_rdata)
    );

    always @(negedge clk) if (m1_write) mem1[m1_addr[6:0]] <= m1_wdata;
    always @(negedge clk) if (m3_write) mem3[m3_addr[6:0]] <= m3_wdata;
    assign m1_rdata = (m1_addr < 32'd128) ? mem1[m1_addr[6:0]] : '0;
    assign m3_rdata = (m3_addr < 32'd128) ? mem3[m3_addr[6:0]] : '0;

    task automatic test_reset;
        c1.req = 0; c1.we = 0; c1.addr = 0; c1.wdata = 0;
        d1.req = 0; d1.we = 0; d1.addr = 0; d1.wdata = 0;
        c3.req = 0; c3.we = 0; c3.addr = 0; c3.wdata = 0;
        d3.req = 0; d3.we = 0; d3.addr = 0; d3.wdata = 0;
        #12;
        checks++; if (c1.gnt !== 1'b0 || d1.gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b want 00", c1.gnt, d1.gnt); end
        checks++; if (c1.rvalid !== 1'b0 || d1.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b want 00", c1.rvalid, d1.rvalid); end
        checks++; if (c1.rdata !== 32'h0 || d1.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h %h want 0", c1.rdata, d1.rdata); end
        checks++; if (m1_write !== 1'b0 || m1_read !== 1'b0 || m3_read !== 1'b0) begin errors++; $display("FAIL reset_mem_strobes: got %b%b%b want 000", m1_write, m1_read, m3_read); end
        checks++; if (m1_addr !== 32'h0 || m1_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus: got %h %h want 0", m1_addr, m1_wdata); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_rw;
        @(negedge clk); c1.req = 1; c1.we = 1; c1.addr = 5; c1.wdata = 32'hDEADBEEF; #1;
        checks++; if (c1.gnt !== 1'b1) begin errors++; $display("FAIL rw_wr_gnt: got %b want 1", c1.gnt); end
        @(negedge clk); c1.req = 0; #1;
        checks++; if (m1_write !== 1'b1 || m1_read !== 1'b0) begin errors++; $display("FAIL rw_wr_strobes: got w%b r%b want w1 r0", m1_write, m1_read); end
        checks++; if (m1_addr !== 32'd5 || m1_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_wr_bus: got %h %h want 5 deadbeef", m1_addr, m1_wdata); end
        @(negedge clk); #1;
        checks++; if (c1.rvalid !== 1'b1 || c1.err !== 1'b0 || m1_write !== 1'b0) begin errors++; $display("FAIL rw_wr_ack: got rv%b err%b w%b want 1 0 0", c1.rvalid, c1.err, m1_write); end
        @(negedge clk); c1.req = 1; c1.we = 0; #1;
        checks++; if (c1.gnt !== 1'b1 || c1.rvalid !== 1'b0) begin errors++; $display("FAIL rw_rd_gnt: got gnt%b rv%b want 1 0", c1.gnt, c1.rvalid); end
        @(negedge clk); c1.req = 0; #1;
        checks++; if (m1_read !== 1'b1 || c1.rvalid !== 1'b0) begin errors++; $display("FAIL rw_rd_access: got r%b rv%b want 1 0", m1_read, c1.rvalid); end
        @(negedge clk); #1;
        checks++; if (c1.rvalid !== 1'b1 || c1.rdata !== 32'hDEADBEEF || c1.err !== 1'b0) begin errors++; $display("FAIL rw_rd_data: got rv%b %h err%b want 1 deadbeef 0", c1.rvalid, c1.rdata, c1.err); end
        checks++; if (d1.rvalid !== 1'b0 || d1.rdata !== 32'h0 || m1_read !== 1'b0) begin errors++; $display("FAIL rw_rd_other: got dma_rv%b %h r%b want 0 0 0", d1.rvalid, d1.rdata, m1_read); end
        @(negedge clk); d1.req = 1; d1.we = 1; d1.addr = 6; d1.wdata = 32'hCAFEF00D; #1;
        checks++; if (d1.gnt !== 1'b1 || c1.gnt !== 1'b0) begin errors++; $display("FAIL rw_dma_gnt: got %b%b want dma only", c1.gnt, d1.gnt); end
        @(negedge clk); d1.req = 0;
        @(negedge clk); #1;
        checks++; if (d1.rvalid !== 1'b1 || c1.rvalid !== 1'b0) begin errors++; $display("FAIL rw_dma_ack: got cpu%b dma%b want 0 1", c1.rvalid, d1.rvalid); end
    endtask

    task automatic test_round_robin;
        logic        own_dma;
        logic [31:0] exp_d;
        @(negedge clk);
        c1.req = 1; c1.we = 0; c1.addr = 5;
        d1.req = 1; d1.we = 0; d1.addr = 6;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            own_dma = ((i / 3) % 2) == 1;
            exp_d   = own_dma ? 32'hCAFEF00D : 32'hDEADBEEF;
            if (i % 3 == 0) begin
                checks++; if (c1.gnt !== !own_dma || d1.gnt !== own_dma) begin errors++; $display("FAIL rr_gnt[%0d]: got cpu%b dma%b want cpu%b dma%b", i, c1.gnt, d1.gnt, !own_dma, own_dma); end
            end else begin
                checks++; if (c1.gnt !== 1'b0 || d1.gnt !== 1'b0) begin errors++; $display("FAIL rr_nogrant[%0d]: got cpu%b dma%b want 00", i, c1.gnt, d1.gnt); end
            end
            if (i % 3 == 2) begin
                checks++; if (c1.rvalid !== !own_dma || d1.rvalid !== own_dma) begin errors++; $display("FAIL rr_rvalid[%0d]: got cpu%b dma%b want cpu%b dma%b", i, c1.rvalid, d1.rvalid, !own_dma, own_dma); end
                checks++; if ((own_dma ? d1.rdata : c1.rdata) !== exp_d) begin errors++; $display("FAIL rr_rdata[%0d]: got %h want %h", i, own_dma ? d1.rdata : c1.rdata, exp_d); end
            end else begin
                checks++; if (c1.rvalid !== 1'b0 || d1.rvalid !== 1'b0) begin errors++; $display("FAIL rr_norvalid[%0d]: got cpu%b dma%b want 00", i, c1.rvalid, d1.rvalid); end
            end
        end
        c1.req = 0; d1.req = 0;
    endtask

    task automatic test_out_of_range;
        @(negedge clk); d1.req = 1; d1.we = 0; d1.addr = 200; #1;
        checks++; if (d1.gnt !== 1'b1 || m1_read !== 1'b0) begin errors++; $display("FAIL oor_gnt: got gnt%b r%b want 1 0", d1.gnt, m1_read); end
        @(negedge clk); d1.req = 0; #1;
        checks++; if (d1.rvalid !== 1'b1 || d1.err !== 1'b1 || d1.rdata !== 32'h0) begin errors++; $display("FAIL oor_resp: got rv%b err%b %h want 1 1 0", d1.rvalid, d1.err, d1.rdata); end
        checks++; if (m1_read !== 1'b0 || m1_write !== 1'b0 || c1.rvalid !== 1'b0) begin errors++; $display("FAIL oor_no_access: got r%b w%b cpu_rv%b want 000", m1_read, m1_write, c1.rvalid); end
        @(negedge clk); #1;
        checks++; if (d1.rvalid !== 1'b0 || m1_read !== 1'b0 || m1_write !== 1'b0) begin errors++; $display("FAIL oor_after: got rv%b r%b w%b want 000", d1.rvalid, m1_read, m1_write); end
    endtask

    task automatic test_latency3;
        @(negedge clk); c3.req = 1; c3.we = 1; c3.addr = 7; c3.wdata = 32'h12345678; #1;
        checks++; if (c3.gnt !== 1'b1) begin errors++; $display("FAIL lat3_wr_gnt: got %b want 1", c3.gnt); end
        @(negedge clk); c3.req = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (c3.rvalid !== 1'b1 || m3_write !== 1'b0) begin errors++; $display("FAIL lat3_wr_ack: got rv%b w%b want 1 0", c3.rvalid, m3_write); end
        @(negedge clk); c3.we = 0; c3.req = 1; #1;
        checks++; if (c3.gnt !== 1'b1) begin errors++; $display("FAIL lat3_rd_gnt: got %b want 1", c3.gnt); end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) c3.req = 0;
            #1;
            checks++; if (m3_read !== (i <= 3)) begin errors++; $display("FAIL lat3_mem_read[%0d]: got %b want %b", i, m3_read, i <= 3); end
            checks++; if (c3.rvalid !== (i == 4)) begin errors++; $display("FAIL lat3_rvalid[%0d]: got %b want %b", i, c3.rvalid, i == 4); end
            if (i == 4) begin
                checks++; if (c3.rdata !== 32'h12345678 || c3.err !== 1'b0) begin errors++; $display("FAIL lat3_rdata: got %h err%b want 12345678 0", c3.rdata, c3.err); end
            end
        end
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk); d1.req = 1; d1.we = 1; d1.addr = 9; d1.wdata = 32'h99; #1;
        checks++; if (d1.gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_gnt: got %b want 1", d1.gnt); end
        @(negedge clk); d1.req = 0; #1;
        checks++; if (m1_write !== 1'b1) begin errors++; $display("FAIL rst_mid_access: got w%b want 1", m1_write); end
        #1 rst_n = 1'b0; #1;
        checks++; if (m1_write !== 1'b0 || m1_read !== 1'b0 || m1_addr !== 32'h0 || m1_wdata !== 32'h0) begin errors++; $display("FAIL rst_mid_mem: got w%b r%b %h %h want all 0", m1_write, m1_read, m1_addr, m1_wdata); end
        checks++; if (d1.rvalid !== 1'b0 || d1.gnt !== 1'b0 || d1.rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_port: got rv%b gnt%b %h want 0", d1.rvalid, d1.gnt, d1.rdata); end
        @(negedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (d1.rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rvalid[%0d]: got %b want 0", i, d1.rvalid); end
        end
        @(negedge clk);
        c1.req = 1; c1.we = 0; c1.addr = 5;
        d1.req = 1; d1.we = 0; d1.addr = 6; #1;
        checks++; if (c1.gnt !== 1'b1 || d1.gnt !== 1'b0) begin errors++; $display("FAIL rst_mid_first_tie: got cpu%b dma%b want cpu1 dma0", c1.gnt, d1.gnt); end
        d1.req = 0;
        @(negedge clk); c1.req = 0;
        @(negedge clk); #1;
        checks++; if (c1.rvalid !== 1'b1 || c1.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_mid_cpu_read: got rv%b %h want 1 deadbeef", c1.rvalid, c1.rdata); end
    endtask

    task automatic test_withdraw;
        @(negedge clk); d1.req = 1; d1.we = 1; d1.addr = 11; d1.wdata = 32'h11; #1;
        checks++; if (d1.gnt !== 1'b1) begin errors++; $display("FAIL wd_dma_gnt: got %b want 1", d1.gnt); end
        @(negedge clk); d1.req = 0; c1.req = 1; c1.we = 0; c1.addr = 5; #1;
        checks++; if (c1.gnt !== 1'b0) begin errors++; $display("FAIL wd_cpu_gnt_access: got %b want 0", c1.gnt); end
        @(negedge clk); c1.req = 0; #1;
        checks++; if (c1.gnt !== 1'b0 || d1.rvalid !== 1'b1) begin errors++; $display("FAIL wd_respond: got cpu_gnt%b dma_rv%b want 0 1", c1.gnt, d1.rvalid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (c1.gnt !== 1'b0 || m1_read !== 1'b0 || m1_write !== 1'b0 || c1.rvalid !== 1'b0) begin errors++; $display("FAIL wd_idle[%0d]: got gnt%b r%b w%b rv%b want 0000", i, c1.gnt, m1_read, m1_write, c1.rvalid); end
        end
    endtask

    initial begin
        test_reset;
        test_rw;
        test_round_robin;
        test_out_of_range;
        test_latency3;
        test_reset_mid_access;
        test_withdraw;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single-port word-addressed data memory (128 x 32, negedge write, level-sensitive read) between two requesters: the CPU load/store path and a DMA/debug loader port.
- Owns every memory control pin, so exactly one access is in flight at a time.
- Uses round-robin arbitration, a req/gnt/rvalid handshake, a programmable memory latency counter, and an out-of-range address check.
- Sits between the MEM stage/loader and the data memory instance.

Parameters:
- DEPTH, 128, number of memory words; valid word addresses are 0..DEPTH-1.
- MEM_LATENCY, 1, cycles mem_read/mem_write are held before read data is sampled (1..15).
- ADDR_W, 32, address width of requester and memory ports.

Ports:
- clock_in  in  1  system clock, rising-edge logic.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU request; held with cpu_we/addr/wdata stable until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  32  write data.
- cpu_gnt  out  1  one-cycle pulse; request accepted this cycle.
- cpu_rvalid  out  1  one-cycle response strobe (read data or write ack).
- cpu_rdata  out  32  read data, valid with cpu_rvalid.
- cpu_err  out  1  out-of-range flag, valid with cpu_rvalid.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata, dma_err: same as cpu_* for the DMA port.
- mem_address  out  ADDR_W  to memory address.
- mem_write_data  out  32  to memory writeData.
- mem_write  out  1  to memory memWrite.
- mem_read  out  1  to memory memRead.
- mem_read_data  in  32  from memory readData.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0, including mem_* and rdata; last_owner=DMA so the CPU wins the first tie; latched request and counter cleared. An in-flight access is dropped with no rvalid.
- States: IDLE, ACCESS, RESPOND.
- IDLE:
  - If any req is high, pick a winner. If only one requests, it wins. If both request, grant the one that is not last_owner.
  - gnt_x is combinational (IDLE & winner), high for that cycle only.
  - On the rising edge, latch owner, we, addr, wdata; set last_owner=owner.
  - If addr >= DEPTH: set err_q=1, rdata_q=0, go to RESPOND with no memory access.
  - Otherwise load count=MEM_LATENCY-1 and go to ACCESS.
- ACCESS (registered outputs):
  - mem_address=addr_q; mem_write_data=wdata_q; mem_write=we_q; mem_read=!we_q.
  - The count decrements each cycle. At count==0: capture mem_read_data into rdata_q (reads only; writes capture 0), err_q=0, go to RESPOND.
  - Repeated negedge writes of identical data when MEM_LATENCY>1 are permitted.
- RESPOND:
  - mem_write=mem_read=0; mem_address/mem_write_data hold their last value.
  - The owner's rvalid=1 with rdata/err driven, for exactly one cycle. The non-owner's rvalid=0 and rdata=0.
  - Next state is IDLE. No request is accepted in RESPOND.
- Throughput: one access per MEM_LATENCY+2 cycles. Response latency: rvalid arrives MEM_LATENCY+1 cycles after gnt (1 cycle for err).
- mem_read deasserts between accesses, so every read produces a fresh edge on the memory's read strobe.
- A request dropped before gnt is withdrawn; no access occurs.
- A requester may raise req again in the cycle after its rvalid.
- Simultaneous req with a new request arriving during ACCESS/RESPOND: it waits and is arbitrated in the next IDLE.
- The address is passed unchanged as a word index; no byte-address shifting.

Decomposition:
- Package dmem_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, RESPOND=2'd2), owner IDs (OWN_CPU=1'b0, OWN_DMA=1'b1), default DEPTH and MEM_LATENCY.
- One sub-module, rr_arb2: two-input round-robin picker with inputs req[1:0] and last_owner, outputs winner and any.
- FSM, latency counter and response muxing stay in dmem_arbiter.

Test Plan:
- Reset release; CPU write addr 5 data 0xDEADBEEF, then CPU read addr 5 -> cpu_gnt pulse; rvalid 2 cycles after gnt (MEM_LATENCY=1); cpu_rdata=0xDEADBEEF, cpu_err=0, dma_rvalid stays 0.
- cpu_req and dma_req both high, held over 4 accesses -> grant order CPU, DMA, CPU, DMA; each rvalid goes to the correct port, one access per 3 cycles.
- DMA read addr 200 (DEPTH=128) -> dma_gnt, then dma_rvalid next cycle with dma_err=1, dma_rdata=0; mem_read and mem_write never assert.
- MEM_LATENCY=3; CPU read addr 7 preloaded 0x12345678 -> mem_read high for exactly 3 cycles; cpu_rvalid 4 cycles after gnt; data correct.
- reset_n pulsed low during ACCESS of a DMA write -> all outputs 0 immediately, no dma_rvalid; after release a CPU request is granted first.
- cpu_req raised, then dropped while a DMA access is in progress -> no cpu_gnt, no memory access for the CPU.
